arrhythmia_class_head: RTL and testbench

ARRHYTHMIA_CLASS_HEAD -- requirements
Module: arrhythmia_class_head

---
 rtl/arrhythmia_class_head_pkg.sv | 17 +
 rtl/arrhythmia_class_head_sm_product.sv | 23 ++
 rtl/arrhythmia_class_head.sv | 128 ++++++++++++
 tb/tb_arrhythmia_class_head.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/arrhythmia_class_head_pkg.sv
// Shared constants and FSM encoding for the arrhythmia classifier heads.
package arrhythmia_class_head_pkg;

  localparam int DEF_BITSIZE   = 16;
  localparam int DEF_FRAC_BITS = 11;
  localparam int N_IN          = 6;
  localparam int N_OUT         = 2;
  localparam int N_MAC         = N_IN * N_OUT;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/arrhythmia_class_head_sm_product.sv
// Sign-magnitude multiply, truncating fraction shift, two's-complement result.
// Latency: combinational.
// Backpressure: none (pure function of its operands).
module sm_product #(
  parameter int BITSIZE   = 16,
  parameter int FRAC_BITS = 11,
  parameter int ACC_W     = 24
) (
  input  logic [BITSIZE-1:0]       a,
  input  logic [BITSIZE-1:0]       b,
  output logic signed [ACC_W-1:0]  p
);

  localparam int MW = BITSIZE - 1;
  localparam int PW = 2 * MW;

  logic [ACC_W-1:0] mag;

  // Shifting the magnitude (not the signed value) truncates toward zero.
  assign mag = ACC_W'((PW'(a[MW-1:0]) * PW'(b[MW-1:0])) >> FRAC_BITS);
  assign p   = (a[MW] ^ b[MW]) ? -mag : mag;

endmodule

// File: rtl/arrhythmia_class_head.sv
// Two-output linear head (6 inputs) with argmax, one serial MAC per cycle.
// Latency: result valid after 13 edges from acceptance.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module arrhythmia_class_head
  import arrhythmia_class_head_pkg::*;
#(
  parameter int BITSIZE   = DEF_BITSIZE,
  parameter int FRAC_BITS = DEF_FRAC_BITS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BITSIZE*N_IN-1:0]    x,
  input  logic [BITSIZE*N_MAC-1:0]   w,
  input  logic [BITSIZE*N_OUT-1:0]   b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BITSIZE*N_OUT-1:0]   y,
  output logic                       class_out
);

  // Wide enough for six full-scale products plus a full-scale bias.
  localparam int ACC_W = (2*BITSIZE - FRAC_BITS + 2 > BITSIZE + 8) ?
                         (2*BITSIZE - FRAC_BITS + 2) : (BITSIZE + 8);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2**(BITSIZE-1) - 1);

  state_t                    state, state_nxt;
  logic [3:0]                k;
  logic [BITSIZE*N_IN-1:0]   x_r;
  logic [BITSIZE*N_MAC-1:0]  w_r;
  logic signed [ACC_W-1:0]   acc0, acc1;
  logic signed [ACC_W-1:0]   prod;
  logic signed [ACC_W-1:0]   sat0, sat1;
  logic [2:0]                i_idx;
  logic [BITSIZE-1:0]        x_sel, w_sel;

  function automatic logic signed [ACC_W-1:0] sm_to_tc(input logic [BITSIZE-1:0] v);
    return v[BITSIZE-1] ? -ACC_W'(v[BITSIZE-2:0]) : ACC_W'(v[BITSIZE-2:0]);
  endfunction

  function automatic logic signed [ACC_W-1:0] sat(input logic signed [ACC_W-1:0] a);
    if (a > SAT_MAX)
      return SAT_MAX;
    else if (a < -SAT_MAX)
      return -SAT_MAX;
    else
      return a;
  endfunction

  // Only strictly negative values get the sign bit, so zero always leaves as +0.
  function automatic logic [BITSIZE-1:0] tc_to_sm(input logic signed [ACC_W-1:0] a);
    return {a[ACC_W-1], (BITSIZE-1)'(a[ACC_W-1] ? -a : a)};
  endfunction

  assign i_idx = 3'((k >= 4'(N_IN)) ? k - 4'(N_IN) : k);
  assign x_sel = x_r[BITSIZE*i_idx +: BITSIZE];
  assign w_sel = w_r[BITSIZE*k +: BITSIZE];
  assign sat0  = sat(acc0);
  assign sat1  = sat(acc1);

  sm_product #(
    .BITSIZE   (BITSIZE),
    .FRAC_BITS (FRAC_BITS),
    .ACC_W     (ACC_W)
  ) u_prod (
    .a (x_sel),
    .b (w_sel),
    .p (prod)
  );

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_MAC;
      end
      ST_MAC:   if (k == 4'(N_MAC - 1)) state_nxt = ST_FINAL;
      ST_FINAL: state_nxt = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      k         <= '0;
      x_r       <= '0;
      w_r       <= '0;
      acc0      <= '0;
      acc1      <= '0;
      y         <= '0;
      class_out <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: if (in_valid) begin
          x_r  <= x;
          w_r  <= w;
          acc0 <= sm_to_tc(b[0 +: BITSIZE]);
          acc1 <= sm_to_tc(b[BITSIZE +: BITSIZE]);
          k    <= '0;
        end
        ST_MAC: begin
          if (k < 4'(N_IN))
            acc0 <= acc0 + prod;
          else
            acc1 <= acc1 + prod;
          k <= k + 4'd1;
        end
        ST_FINAL: begin
          y         <= {tc_to_sm(sat1), tc_to_sm(sat0)};
          class_out <= (sat1 > sat0);
          k         <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arrhythmia_class_head.sv
// Directed plus randomized checks of arrhythmia_class_head against an arithmetic model.
module tb_arrhythmia_class_head;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [95:0]  x;
  logic [191:0] w;
  logic [31:0]  b;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  y;
  logic         class_out;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  arrhythmia_class_head #(.BITSIZE(16), .FRAC_BITS(11)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .w         (w),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .class_out (class_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint smv(input logic [15:0] v);
    return v[15] ? -longint'(v[14:0]) : longint'(v[14:0]);
  endfunction

  function automatic logic [15:0] enc(input longint s);
    longint c;
    c = (s > 32767) ? 32767 : ((s < -32767) ? -32767 : s);
    return (c < 0) ? {1'b1, 15'(-c)} : {1'b0, 15'(c)};
  endfunction

  // Returns {class, y1, y0}.
  function automatic logic [32:0] ref_model(input logic [95:0] xv, input logic [191:0] wv,
                                            input logic [31:0] bv);
    longint s [2];
    longint c [2];
    longint mag;
    logic [15:0] xe, we;
    for (int n = 0; n < 2; n++) begin
      s[n] = smv(bv[16*n +: 16]);
      for (int i = 0; i < 6; i++) begin
        xe  = xv[16*i +: 16];
        we  = wv[16*(6*n+i) +: 16];
        mag = (longint'(xe[14:0]) * longint'(we[14:0])) / 2048;
        s[n] += (xe[15] ^ we[15]) ? -mag : mag;
      end
      c[n] = (s[n] > 32767) ? 32767 : ((s[n] < -32767) ? -32767 : s[n]);
    end
    return {(c[1] > c[0]) ? 1'b1 : 1'b0, enc(s[1]), enc(s[0])};
  endfunction

  function automatic logic [15:0] rw();
    case ($urandom % 8)
      0:       return 16'h8000;
      1:       return 16'h0000;
      2:       return 16'h7FFF;
      3:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic run_txn(input string tag, input logic [95:0] xv, input logic [191:0] wv,
                         input logic [31:0] bv, input logic [32:0] exp, input int stall);
    int cyc;
    @(negedge clk);
    x = xv; w = wv; b = bv; in_valid = 1'b1; out_ready = 1'b0;
    chk($sformatf("%s_in_ready", tag), 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    x = {$urandom, $urandom, $urandom};
    w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    b = $urandom;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      in_valid = 1'($urandom);
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk($sformatf("%s_latency", tag), 64'(cyc), 64'd13);
    chk($sformatf("%s_result", tag), 64'({class_out, y}), 64'(exp));
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'($urandom);
      @(negedge clk);
      chk($sformatf("%s_hold%0d", tag, s), 64'({out_valid, in_ready, class_out, y}),
          64'({2'b10, exp}));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk($sformatf("%s_release", tag), 64'({out_valid, in_ready}), 64'b01);
  endtask

  localparam logic [95:0]  X_ONE  = {6{16'h0800}};
  localparam logic [191:0] W_029  = {{6{16'h0200}}, {6{16'h0400}}};
  localparam logic [191:0] W_030  = {{6{16'h0400}}, {6{16'h0000}}};
  localparam logic [191:0] W_031  = {{6{16'hFFFF}}, {6{16'h7FFF}}};

  initial begin
    logic [95:0]  rx;
    logic [191:0] rwv;
    logic [31:0]  rb;
    logic         saw_valid;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = '0; w = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", 64'({out_valid, in_ready, class_out, y}), 64'({2'b01, 33'd0}));
    reset = 1'b0;

    run_txn("basic", X_ONE, W_029, 32'h0, 33'h0_0C00_1800, 5);
    run_txn("neg_bias", X_ONE, W_030, {16'h0000, 16'h8800}, 33'h1_1800_8800, 0);
    run_txn("saturate", {6{16'h7FFF}}, W_031, 32'h0, 33'h0_FFFF_7FFF, 1);
    run_txn("neg_zero", {6{16'h8000}},
            {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
            {16'h0000, 16'h8000}, 33'h0_0000_0000, 0);

    // Reset in the middle of MAC must drop the transaction without a result.
    @(negedge clk);
    x = X_ONE; w = W_031; b = 32'h1234_5678; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midmac_reset", 64'({out_valid, in_ready, class_out, y}), 64'({2'b01, 33'd0}));
    saw_valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      saw_valid |= out_valid;
    end
    chk("midmac_no_valid", 64'(saw_valid), 64'd0);
    run_txn("after_reset", X_ONE, W_029, 32'h0, 33'h0_0C00_1800, 0);

    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 6; i++) rx[16*i +: 16] = rw();
      for (int i = 0; i < 12; i++) rwv[16*i +: 16] = rw();
      rb = {rw(), rw()};
      run_txn($sformatf("rand%0d", t), rx, rwv, rb, ref_model(rx, rwv, rb),
              int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
